// File: rtl/alu_rs_pkg.sv
// Shared types, sizes and opcode encodings for the ALU reservation station.
// Operand snooping helper used for both issue-time bypass and per-cycle wakeup.
`default_nettype none
package alu_rs_pkg;

    localparam int RS_SIZE_DEF   = 8;
    localparam int RS_SZ_LOG_DEF = 3;
    localparam int ROB_SZ_LOG    = 4;
    localparam int TAG_W         = ROB_SZ_LOG + 1;
    localparam int OP_W          = 5;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [OP_W-1:0]  op_t;

    localparam op_t OP_ADD  = 5'd1;
    localparam op_t OP_SUB  = 5'd2;
    localparam op_t OP_AND  = 5'd3;
    localparam op_t OP_OR   = 5'd4;
    localparam op_t OP_XOR  = 5'd5;
    localparam op_t OP_SLL  = 5'd6;
    localparam op_t OP_SRL  = 5'd7;
    localparam op_t OP_SLT  = 5'd8;
    localparam op_t OP_BEQ  = 5'd9;
    localparam op_t OP_JAL  = 5'd10;

    typedef struct packed {
        logic        pend;
        tag_t        q;
        logic [31:0] v;
    } opnd_t;

    typedef struct packed {
        logic        busy;
        op_t         op;
        opnd_t       j;
        opnd_t       k;
        logic [31:0] imm;
        logic [31:0] pc;
        tag_t        rob;
    } entry_t;

    // ROB tags are unique, so at most one bus can match; ALU bus checked first.
    function automatic opnd_t snoop(
        input opnd_t       o,
        input logic        af,
        input tag_t        ar,
        input logic [31:0] ares,
        input logic        lf,
        input tag_t        lr,
        input logic [31:0] lres
    );
        opnd_t r;
        r = o;
        if (o.pend) begin
            if (af && (ar == o.q)) begin
                r.pend = 1'b0;
                r.v    = ares;
            end else if (lf && (lr == o.q)) begin
                r.pend = 1'b0;
                r.v    = lres;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_pick.sv
// Lowest-index priority picker: request vector in, grant index plus valid out.
`default_nettype none
module rs_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until operands are ready,
// snoops ALU/LSB result buses, dispatches one ready op per cycle to registered outputs.
`default_nettype none
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE   = RS_SIZE_DEF,
    parameter int RS_SZ_LOG = RS_SZ_LOG_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        iss_en,
    input  op_t         iss_op,
    input  logic [31:0] iss_vj,
    input  logic [31:0] iss_vk,
    input  tag_t        iss_qj,
    input  tag_t        iss_qk,
    input  logic        iss_qj_busy,
    input  logic        iss_qk_busy,
    input  logic [31:0] iss_imm,
    input  logic [31:0] iss_pc,
    input  tag_t        iss_rob,
    output logic        full,
    input  logic        alu_flg,
    input  tag_t        alu_rd,
    input  logic [31:0] alu_res,
    input  logic        lsb_flg,
    input  tag_t        lsb_rd,
    input  logic [31:0] lsb_res,
    output logic        run_flg,
    output tag_t        rd_fr,
    output logic [31:0] Vj,
    output logic [31:0] Vk,
    output logic [31:0] imm,
    output logic [31:0] pc,
    output op_t         opcode
);

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];

    logic        run_q, run_d;
    tag_t        rd_q, rd_d;
    logic [31:0] vj_q, vj_d, vk_q, vk_d, imm_q, imm_d, pc_q, pc_d;
    op_t         op_q, op_d;

    logic [RS_SIZE-1:0]   busy_vec, ready_vec;
    logic [RS_SZ_LOG-1:0] free_idx, rdy_idx;
    logic                 free_vld, rdy_vld;
    opnd_t                new_j, new_k;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && !ent_q[i].j.pend && !ent_q[i].k.pend;
        end
    end

    assign full = &busy_vec;

    rs_pick #(.N(RS_SIZE), .W(RS_SZ_LOG)) u_free_pick (
        .req_i (~busy_vec),
        .idx_o (free_idx),
        .vld_o (free_vld)
    );

    rs_pick #(.N(RS_SIZE), .W(RS_SZ_LOG)) u_ready_pick (
        .req_i (ready_vec),
        .idx_o (rdy_idx),
        .vld_o (rdy_vld)
    );

    always_comb begin
        ent_d = ent_q;
        run_d = 1'b0;
        rd_d  = rd_q;
        vj_d  = vj_q;
        vk_d  = vk_q;
        imm_d = imm_q;
        pc_d  = pc_q;
        op_d  = op_q;
        new_j = snoop('{pend: iss_qj_busy, q: iss_qj, v: iss_vj},
                      alu_flg, alu_rd, alu_res, lsb_flg, lsb_rd, lsb_res);
        new_k = snoop('{pend: iss_qk_busy, q: iss_qk, v: iss_vk},
                      alu_flg, alu_rd, alu_res, lsb_flg, lsb_rd, lsb_res);
        if (!rdy_in) begin
            run_d = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    ent_d[i].j = snoop(ent_q[i].j, alu_flg, alu_rd, alu_res, lsb_flg, lsb_rd, lsb_res);
                    ent_d[i].k = snoop(ent_q[i].k, alu_flg, alu_rd, alu_res, lsb_flg, lsb_rd, lsb_res);
                end
            end
            // Ready set comes from current state, so a just-woken entry waits a cycle.
            if (rdy_vld) begin
                run_d = 1'b1;
                rd_d  = ent_q[rdy_idx].rob;
                vj_d  = ent_q[rdy_idx].j.v;
                vk_d  = ent_q[rdy_idx].k.v;
                imm_d = ent_q[rdy_idx].imm;
                pc_d  = ent_q[rdy_idx].pc;
                op_d  = ent_q[rdy_idx].op;
                ent_d[rdy_idx].busy = 1'b0;
            end
            if (iss_en && free_vld) begin
                ent_d[free_idx] = '{busy: 1'b1, op: iss_op, j: new_j, k: new_k,
                                    imm: iss_imm, pc: iss_pc, rob: iss_rob};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            run_q <= 1'b0;
            rd_q  <= '0;
            vj_q  <= '0;
            vk_q  <= '0;
            imm_q <= '0;
            pc_q  <= '0;
            op_q  <= '0;
        end else begin
            ent_q <= ent_d;
            run_q <= run_d;
            rd_q  <= rd_d;
            vj_q  <= vj_d;
            vk_q  <= vk_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
            op_q  <= op_d;
        end
    end

    assign run_flg = run_q;
    assign rd_fr   = rd_q;
    assign Vj      = vj_q;
    assign Vk      = vk_q;
    assign imm     = imm_q;
    assign pc      = pc_q;
    assign opcode  = op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: stimulus pushes expected dispatches, a negedge monitor checks them.
`default_nettype none
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush, iss_en;
    op_t         iss_op;
    logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
    tag_t        iss_qj, iss_qk, iss_rob;
    logic        iss_qj_busy, iss_qk_busy;
    logic        full;
    logic        alu_flg, lsb_flg;
    tag_t        alu_rd, lsb_rd;
    logic [31:0] alu_res, lsb_res;
    logic        run_flg;
    tag_t        rd_fr;
    logic [31:0] Vj, Vk, imm, pc;
    op_t         opcode;

    always #5 clk_in = ~clk_in;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .iss_en(iss_en),
        .iss_op(iss_op), .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk),
        .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_rob(iss_rob), .full(full), .alu_flg(alu_flg), .alu_rd(alu_rd), .alu_res(alu_res),
        .lsb_flg(lsb_flg), .lsb_rd(lsb_rd), .lsb_res(lsb_res), .run_flg(run_flg), .rd_fr(rd_fr),
        .Vj(Vj), .Vk(Vk), .imm(imm), .pc(pc), .opcode(opcode)
    );

    typedef struct {
        tag_t        rob;
        logic [31:0] vj, vk, imm, pc;
        op_t         op;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (rst_in === 1'b1 && run_flg === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: actual rd_fr=%h required no dispatch", rd_fr);
            end else begin
                e = sb.pop_front();
                checks++;
                if (rd_fr !== e.rob || Vj !== e.vj || Vk !== e.vk || imm !== e.imm ||
                    pc !== e.pc || opcode !== e.op) begin
                    errors++;
                    $display("FAIL dispatch: actual rd=%h vj=%h vk=%h imm=%h pc=%h op=%h required rd=%h vj=%h vk=%h imm=%h pc=%h op=%h",
                             rd_fr, Vj, Vk, imm, pc, opcode, e.rob, e.vj, e.vk, e.imm, e.pc, e.op);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input op_t op, input logic [31:0] vj, input tag_t qj, input logic qjb,
                         input logic [31:0] vk, input tag_t qk, input logic qkb,
                         input logic [31:0] im, input logic [31:0] p, input tag_t rob);
        iss_en = 1'b1; iss_op = op; iss_vj = vj; iss_qj = qj; iss_qj_busy = qjb;
        iss_vk = vk; iss_qk = qk; iss_qk_busy = qkb; iss_imm = im; iss_pc = p; iss_rob = rob;
        step();
        iss_en = 1'b0;
    endtask

    task automatic push(input tag_t rob, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] im, input logic [31:0] p, input op_t op);
        exp_t e;
        e.rob = rob; e.vj = vj; e.vk = vk; e.imm = im; e.pc = p; e.op = op;
        sb.push_back(e);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; iss_en = 1'b0;
        iss_op = '0; iss_vj = '0; iss_vk = '0; iss_qj = '0; iss_qk = '0;
        iss_qj_busy = 1'b0; iss_qk_busy = 1'b0; iss_imm = '0; iss_pc = '0; iss_rob = '0;
        alu_flg = 1'b0; alu_rd = '0; alu_res = '0; lsb_flg = 1'b0; lsb_rd = '0; lsb_res = '0;
        step(); step();
        chk("reset_run_flg", run_flg, 0);
        chk("reset_full", full, 0);
        chk("reset_rd_fr", rd_fr, 0);
        chk("reset_opcode", opcode, 0);
        rst_in = 1'b1;
        step();

        // Ready issue: two edges to run_flg
        push(5'd3, 32'd5, 32'd7, 32'h11, 32'h100, OP_ADD);
        issue(OP_ADD, 32'd5, 5'd0, 1'b0, 32'd7, 5'd0, 1'b0, 32'h11, 32'h100, 5'd3);
        chk("ready_latency_edge1", run_flg, 0);
        step();
        chk("ready_latency_edge2", run_flg, 1);

        // Wakeup via ALU bus
        push(5'd5, 32'h10, 32'd2, 32'h22, 32'h104, OP_SUB);
        issue(OP_SUB, 32'd0, 5'd4, 1'b1, 32'd2, 5'd0, 1'b0, 32'h22, 32'h104, 5'd5);
        alu_flg = 1'b1; alu_rd = 5'd4; alu_res = 32'h10;
        step();
        alu_flg = 1'b0;
        chk("wake_not_same_cycle", run_flg, 0);
        step();
        chk("wake_dispatch", run_flg, 1);

        // Issue bypass from LSB bus
        push(5'd11, 32'd3, 32'd9, 32'h33, 32'h108, OP_XOR);
        lsb_flg = 1'b1; lsb_rd = 5'd6; lsb_res = 32'd9;
        issue(OP_XOR, 32'd3, 5'd0, 1'b0, 32'd0, 5'd6, 1'b1, 32'h33, 32'h108, 5'd11);
        lsb_flg = 1'b0;
        chk("bypass_edge1", run_flg, 0);
        step();
        chk("bypass_dispatch", run_flg, 1);

        // Fill all entries with pending ops, then overflow
        for (int i = 0; i < 8; i++)
            issue(OP_AND, 32'd0, tag_t'(10 + i), 1'b1, 32'(i), 5'd0, 1'b0, 32'(i), 32'h200 + 32'(4 * i), tag_t'(20 + i));
        chk("full_after_8", full, 1);
        issue(OP_OR, 32'd1, 5'd0, 1'b0, 32'd1, 5'd0, 1'b0, 32'd0, 32'h300, 5'd31);
        chk("full_after_ignored_9th", full, 1);

        // Wake entries 5 (ALU) and 2 (LSB) together: 2 dispatches first
        push(5'd22, 32'h22, 32'd2, 32'd2, 32'h208, OP_AND);
        push(5'd25, 32'h55, 32'd5, 32'd5, 32'h214, OP_AND);
        alu_flg = 1'b1; alu_rd = 5'd15; alu_res = 32'h55;
        lsb_flg = 1'b1; lsb_rd = 5'd12; lsb_res = 32'h22;
        step();
        alu_flg = 1'b0; lsb_flg = 1'b0;
        chk("prio_wake_latency", run_flg, 0);
        step();
        chk("prio_first_run", run_flg, 1);
        chk("prio_full_cleared", full, 0);
        step();
        chk("prio_second_run", run_flg, 1);
        step();
        chk("prio_idle", run_flg, 0);

        // Flush with busy entries and a simultaneous issue
        flush = 1'b1;
        issue(OP_ADD, 32'd1, 5'd0, 1'b0, 32'd1, 5'd0, 1'b0, 32'd0, 32'h400, 5'd30);
        flush = 1'b0;
        chk("flush_full", full, 0);
        chk("flush_run_flg", run_flg, 0);
        alu_flg = 1'b1; alu_rd = 5'd10; alu_res = 32'h1;
        step();
        alu_rd = 5'd11; lsb_flg = 1'b1; lsb_rd = 5'd13;
        step();
        alu_flg = 1'b0; lsb_flg = 1'b0;
        step(); step();
        chk("flush_no_dispatch", run_flg, 0);

        // rdy_in low holds state for three cycles; issue during hold is dropped
        push(5'd7, 32'd1, 32'd2, 32'h44, 32'h500, OP_SLT);
        issue(OP_SLT, 32'd1, 5'd0, 1'b0, 32'd2, 5'd0, 1'b0, 32'h44, 32'h500, 5'd7);
        rdy_in = 1'b0;
        issue(OP_BEQ, 32'd8, 5'd0, 1'b0, 32'd8, 5'd0, 1'b0, 32'd0, 32'h504, 5'd8);
        chk("hold_run1", run_flg, 0);
        step();
        chk("hold_run2", run_flg, 0);
        step();
        chk("hold_run3", run_flg, 0);
        chk("hold_outputs", Vk, 32'd5);
        rdy_in = 1'b1;
        step();
        chk("hold_release_run", run_flg, 1);
        step();
        chk("hold_dropped_issue", run_flg, 0);

        // Asynchronous reset mid-traffic
        issue(OP_SLL, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 32'h600, 5'd9);
        push(5'd10, 32'h80, 32'd3, 32'h66, 32'h604, OP_SRL);
        issue(OP_SRL, 32'h80, 5'd0, 1'b0, 32'd3, 5'd0, 1'b0, 32'h66, 32'h604, 5'd10);
        step();
        #6;
        rst_in = 1'b0;
        #1;
        chk("async_rst_run_flg", run_flg, 0);
        chk("async_rst_rd_fr", rd_fr, 0);
        chk("async_rst_vj", Vj, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_full", full, 0);
        step();
        rst_in = 1'b1;
        alu_flg = 1'b1; alu_rd = 5'd9; alu_res = 32'h7;
        step();
        alu_flg = 1'b0;
        step(); step();
        chk("post_rst_no_dispatch", run_flg, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
